// File: rtl/apb_arbiter_master_if.sv
// Requester command/response ports and APB bus of apb_arbiter_master.
// The master modport is the arbiter's view; the slave modport is the view of the clients and the APB slave.
interface apb_arbiter_master_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;
  logic [ADDR_WIDTH-1:0]         PADDR;
  logic [DATA_WIDTH-1:0]         PWDATA;
  logic                          PWRITE;
  logic                          PSEL;
  logic                          PENABLE;
  logic                          PREADY;
  logic [DATA_WIDTH-1:0]         PRDATA;
  logic                          PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/apb_arbiter_master.sv
// Round-robin APB master sharing one APB slave among NUM_REQ requesters.
// Optional ACCESS-phase timeout abort is enabled by defining APB_ARB_TIMEOUT_EN.
//
// state    | meaning
// S_IDLE   | bus idle; accept the round-robin winner and latch its command
// S_SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
// S_ACCESS | PSEL=1, PENABLE=1 until PREADY (or timeout abort)
module apb_arbiter_master #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                  PCLK,
  input logic                  PRESETn,
  apb_arbiter_master_if.master bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t                r_state;
  logic [GW-1:0]         r_last_grant;
  logic [NUM_REQ-1:0]    r_grant_oh;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_pwrite;
  logic                  r_psel;
  logic                  r_penable;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_found;
  logic [GW-1:0]         w_grant;
  logic [NUM_REQ-1:0]    w_grant_oh;
  logic [NUM_REQ-1:0]    w_ready;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_write;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] r_tmo_cnt;
`endif

  // Search from last_grant+1 upward, wrapping to 0.
  always_comb begin
    int v_idx;
    w_found = 1'b0;
    w_grant = r_last_grant;
    v_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_idx = int'(r_last_grant) + k;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      if (!w_found && bus.req_valid[GW'(v_idx)]) begin
        w_found = 1'b1;
        w_grant = GW'(v_idx);
      end
    end
  end

  always_comb begin
    w_addr     = '0;
    w_wdata    = '0;
    w_write    = 1'b0;
    w_grant_oh = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (GW'(k) == w_grant) begin
        w_grant_oh[k] = 1'b1;
        w_addr        = bus.req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata       = bus.req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        w_write       = bus.req_write[k];
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (r_state == S_IDLE && w_found) w_ready = w_grant_oh;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state      <= S_IDLE;
      r_last_grant <= GW'(NUM_REQ-1);
      r_grant_oh   <= '0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_pwrite     <= 1'b0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      r_tmo_cnt    <= '0;
`endif
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_last_grant <= w_grant;
            r_grant_oh   <= w_grant_oh;
            r_paddr      <= w_addr;
            r_pwdata     <= w_wdata;
            r_pwrite     <= w_write;
            r_psel       <= 1'b1;
            r_state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          r_tmo_cnt <= TW'(TIMEOUT_CYCLES-1);
`endif
        end
        S_ACCESS: begin
          // PREADY takes priority over an expiring timeout in the same cycle.
          if (bus.PREADY) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= S_IDLE;
            r_rsp_valid <= r_grant_oh;
            r_rsp_rdata <= r_pwrite ? '0 : bus.PRDATA;
            r_rsp_err   <= bus.PSLVERR;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (r_tmo_cnt == '0) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= S_IDLE;
            r_rsp_valid <= r_grant_oh;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt - 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
endmodule

// File: tb/tb_apb_arbiter_master.sv
// Scoreboard bench for apb_arbiter_master: randomized requesters, a 1024-word APB memory slave,
// and a transaction-level reference model predicting grants, bus phases and responses.
module tb_apb_arbiter_master;
  localparam int NUM_REQ = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TMO     = 4;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_arbiter_master_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_arbiter_master #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wt;
  } cmd_t;

  typedef struct {
    int          req;
    logic [31:0] rdata;
    logic        err;
    longint      due;
  } exp_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  bit     in_reset = 1'b1;
  bit     mon_en   = 1'b0;
  bit     drop_en  = 1'b0;

  cmd_t   cmdq[NUM_REQ][$];
  cmd_t   pend_cmd[NUM_REQ];
  bit     pend[NUM_REQ];
  exp_t   sbq[$];
  int     glog[$];

  // Reference model state: last grant, memory image, and the transfer currently on the bus.
  int          m_last      = NUM_REQ-1;
  longint      m_next_idle = 0;
  bit [31:0]   m_mem[1024];
  longint      x_acc = -100;
  int          x_we  = 0;
  logic [31:0] x_addr  = '0;
  logic [31:0] x_wdata = '0;
  logic        x_wr    = 1'b0;

  // APB memory slave: zero-wait by default, s_wait extra cycles on request, one wait on error.
  bit [31:0] s_mem[1024];
  int        s_cnt  = 0;
  int        s_wait = 0;
  int        s_need;

  always_comb begin
    s_need      = (bus.PADDR >= 32'd1024) ? 1 : s_wait;
    bus.PREADY  = bus.PSEL && bus.PENABLE && (s_cnt >= s_need);
    bus.PSLVERR = bus.PREADY && (bus.PADDR >= 32'd1024);
    bus.PRDATA  = (bus.PADDR < 32'd1024) ? s_mem[bus.PADDR[9:0]] : '0;
  end

  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (bus.PSEL && bus.PENABLE && !bus.PREADY) s_cnt <= s_cnt + 1;
    else s_cnt <= 0;
    if (bus.PREADY && bus.PWRITE && bus.PADDR < 32'd1024) s_mem[bus.PADDR[9:0]] <= bus.PWDATA;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic cmd_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input int wt);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wdata; c.wt = wt;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c.wr    = 1'($urandom_range(0, 1));
    c.addr  = ($urandom_range(0, 9) == 0) ? 32'd1024 + $urandom_range(0, 100) : 32'($urandom_range(0, 31));
    c.wdata = $urandom;
    c.wt    = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
    return c;
  endfunction

  task automatic check_reset_outputs(input string name);
    check(name, {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA,
                 bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, '0);
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge PCLK);
      done = (sbq.size() == 0) && (cyc >= m_next_idle);
      for (int i = 0; i < NUM_REQ; i++) if (pend[i] || cmdq[i].size() != 0) done = 1'b0;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: traffic still outstanding after %0d cycles, required none", budget);
    end
  endtask

  // Requester driver plus the model's prediction of each IDLE-cycle grant.
  initial begin : driver
    logic [NUM_REQ-1:0] v_valid;
    logic [NUM_REQ-1:0] exp_ready;
    int   g;
    int   we;
    int   obs;
    logic abort;
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (in_reset) begin
        bus.req_valid = '0;
        m_last      = NUM_REQ-1;
        m_next_idle = 0;
        x_acc       = -100;
        sbq.delete();
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!pend[i] && cmdq[i].size() > 0) begin
            pend_cmd[i] = cmdq[i].pop_front();
            pend[i]     = 1'b1;
          end
          v_valid[i]               = pend[i] && !(drop_en && $urandom_range(0, 7) == 0);
          bus.req_write[i]         = pend_cmd[i].wr;
          bus.req_addr[i*AW +: AW] = pend_cmd[i].addr;
          bus.req_wdata[i*DW +: DW] = pend_cmd[i].wdata;
        end
        bus.req_valid = v_valid;
        #1;
        g = -1;
        exp_ready = '0;
        if (cyc >= m_next_idle) begin
          for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (m_last + k) % NUM_REQ;
            if (g < 0 && v_valid[idx]) g = idx;
          end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", bus.req_ready, exp_ready);
        obs = -1;
        for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i] && obs < 0) obs = i;
        if (obs >= 0) glog.push_back(obs);
        if (g >= 0) begin
          we    = (pend_cmd[g].addr >= 32'd1024) ? 1 : pend_cmd[g].wt;
          abort = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
          if (we >= TMO) begin
            abort = 1'b1;
            we    = TMO - 1;
          end
`endif
          e.req = g;
          e.due = cyc + 3 + we;
          e.rdata = '0;
          e.err   = 1'b0;
          if (abort || pend_cmd[g].addr >= 32'd1024) e.err = 1'b1;
          else if (pend_cmd[g].wr) m_mem[pend_cmd[g].addr[9:0]] = pend_cmd[g].wdata;
          else e.rdata = m_mem[pend_cmd[g].addr[9:0]];
          sbq.push_back(e);
          x_acc       = cyc;
          x_we        = we;
          x_addr      = pend_cmd[g].addr;
          x_wdata     = pend_cmd[g].wdata;
          x_wr        = pend_cmd[g].wr;
          m_next_idle = cyc + 3 + we;
          s_wait      = pend_cmd[g].wt;
          pend[g]     = 1'b0;
          m_last      = g;
        end
      end
    end
  end

  // Monitor: bus phases and stable command every cycle; responses popped from the scoreboard.
  initial begin : monitor
    logic exp_psel;
    logic exp_pen;
    logic [NUM_REQ-1:0] oh;
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (mon_en && !in_reset) begin
        exp_psel = (cyc >= x_acc + 1) && (cyc <= x_acc + 2 + x_we);
        exp_pen  = (cyc >= x_acc + 2) && (cyc <= x_acc + 2 + x_we);
        check("psel_penable", {bus.PSEL, bus.PENABLE}, {exp_psel, exp_pen});
        if (exp_psel)
          check("paddr_pwrite_pwdata", {bus.PADDR, bus.PWRITE, bus.PWDATA}, {x_addr, x_wr, x_wdata});
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
          e  = sbq.pop_front();
          oh = '0;
          oh[e.req] = 1'b1;
          check("rsp_valid", bus.rsp_valid, oh);
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          check("rsp_err", bus.rsp_err, e.err);
        end else begin
          check("rsp_valid_quiet", bus.rsp_valid, '0);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int  base;
    bit  found;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #2;
    check_reset_outputs("reset_outputs");

    // Both requesters busy from reset: grants must alternate starting at 0.
    for (int j = 0; j < 3; j++) begin
      cmdq[0].push_back(mk(1'b1, 32'(j), 32'hA000_0000 + 32'(j), 0));
      cmdq[1].push_back(mk(1'b0, 32'(j + 4), 32'h0, 0));
    end
    repeat (2) @(negedge PCLK);
    #2;
    PRESETn  = 1'b1;
    in_reset = 1'b0;
    mon_en   = 1'b1;
    base     = glog.size();
    wait_drain(200);
    for (int j = 0; j < 6; j++)
      check("alternate_grant", (base + j < glog.size()) ? glog[base + j] : -1, j % 2);

    // Write then read back through requester 0.
    cmdq[0].push_back(mk(1'b1, 32'h10, 32'hDEADBEEF, 0));
    cmdq[0].push_back(mk(1'b0, 32'h10, 32'h0, 0));
    wait_drain(200);

    // Out-of-range read gets the slave error; the following transfer is normal.
    cmdq[1].push_back(mk(1'b0, 32'h400, 32'h0, 0));
    cmdq[0].push_back(mk(1'b0, 32'h10, 32'h0, 0));
    wait_drain(200);

    // Slow slave: five wait states, bus held stable.
    cmdq[0].push_back(mk(1'b1, 32'h30, 32'h1234_5678, 5));
    cmdq[1].push_back(mk(1'b0, 32'h30, 32'h0, 0));
    wait_drain(200);

`ifdef APB_ARB_TIMEOUT_EN
    cmdq[0].push_back(mk(1'b1, 32'h31, 32'hCAFE_F00D, 50));
    cmdq[1].push_back(mk(1'b0, 32'h31, 32'h0, 3));
    cmdq[0].push_back(mk(1'b1, 32'h32, 32'h0BAD_CAFE, 4));
    wait_drain(400);
`endif

    // Reset in the middle of an ACCESS phase.
    cmdq[0].push_back(mk(1'b0, 32'h11, 32'h0, 5));
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge PCLK);
      if (bus.PSEL && bus.PENABLE) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL reset_wait: ACCESS phase not reached within 100 cycles, required reached");
    end
    #2;
    PRESETn  = 1'b0;
    in_reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid_outputs");
    cmdq[1].push_back(mk(1'b0, 32'h12, 32'h0, 0));
    cmdq[0].push_back(mk(1'b0, 32'h13, 32'h0, 0));
    repeat (3) @(negedge PCLK);
    #2;
    PRESETn  = 1'b1;
    in_reset = 1'b0;
    base     = glog.size();
    wait_drain(200);
    check("first_grant_after_reset", (base < glog.size()) ? glog[base] : -1, 0);

    // Randomized traffic with requesters occasionally withdrawing valid before accept.
    drop_en = 1'b1;
    for (int j = 0; j < 60; j++)
      for (int i = 0; i < NUM_REQ; i++) cmdq[i].push_back(rnd_cmd());
    wait_drain(5000);
    drop_en = 1'b0;
    repeat (3) @(negedge PCLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
